// File: rtl/ram_word_arbiter.sv
// Two-port round-robin arbiter that turns 32-bit word reads/writes into four
// little-endian byte accesses on a single byte-wide ram.
//
// state   | meaning
// IDLE    | no transaction; arbitrate between req0/req1
// WR0-WR3 | drive write byte k of the latched word
// RD0-RD3 | present read address byte k; capture byte k-1 from the ram
// RDTAIL  | capture the last read byte
// DONE    | one-cycle ack to the granted port
module ram_word_arbiter #(
  parameter int logHeight = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [logHeight-1:0] addr0,
  input  logic [31:0]          wdata0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [logHeight-1:0] addr1,
  input  logic [31:0]          wdata1,
  output logic                 ack1,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 grant,
  output logic [7:0]           ram_bytein,
  output logic [logHeight+1:0] ram_adr,
  output logic                 ram_rwn,
  input  logic [7:0]           ram_byteout
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR0, S_WR1, S_WR2, S_WR3,
    S_RD0, S_RD1, S_RD2, S_RD3, S_RDTAIL, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 we_q, we_d;
  logic [logHeight-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 win;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    win          = 1'b0;
    ram_rwn      = 1'b1;
    ram_adr      = '0;
    ram_bytein   = '0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Under contention the port that was not served last wins.
          win          = (req0 && req1) ? ~last_grant_q : req1;
          grant_d      = win;
          last_grant_d = win;
          we_d         = win ? we1 : we0;
          addr_d       = win ? addr1 : addr0;
          wdata_d      = win ? wdata1 : wdata0;
          state_d      = we_d ? S_WR0 : S_RD0;
        end
      end
      S_WR0: begin
        ram_rwn    = 1'b0;
        ram_adr    = {addr_q, 2'd0};
        ram_bytein = wdata_q[7:0];
        state_d    = S_WR1;
      end
      S_WR1: begin
        ram_rwn    = 1'b0;
        ram_adr    = {addr_q, 2'd1};
        ram_bytein = wdata_q[15:8];
        state_d    = S_WR2;
      end
      S_WR2: begin
        ram_rwn    = 1'b0;
        ram_adr    = {addr_q, 2'd2};
        ram_bytein = wdata_q[23:16];
        state_d    = S_WR3;
      end
      S_WR3: begin
        ram_rwn    = 1'b0;
        ram_adr    = {addr_q, 2'd3};
        ram_bytein = wdata_q[31:24];
        state_d    = S_DONE;
      end
      S_RD0: begin
        ram_adr = {addr_q, 2'd0};
        state_d = S_RD1;
      end
      // Ram output lags the address by one edge, so each RD state captures the previous byte.
      S_RD1: begin
        ram_adr       = {addr_q, 2'd1};
        rdata_d[7:0]  = ram_byteout;
        state_d       = S_RD2;
      end
      S_RD2: begin
        ram_adr        = {addr_q, 2'd2};
        rdata_d[15:8]  = ram_byteout;
        state_d        = S_RD3;
      end
      S_RD3: begin
        ram_adr         = {addr_q, 2'd3};
        rdata_d[23:16]  = ram_byteout;
        state_d         = S_RDTAIL;
      end
      S_RDTAIL: begin
        rdata_d[31:24] = ram_byteout;
        state_d        = S_DONE;
      end
      S_DONE: begin
        ack0    = ~grant_q;
        ack1    = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);
  assign grant = grant_q;

endmodule

// File: doc/ram_word_arbiter.md
Name: ram_word_arbiter

Overview:
Two-port round-robin arbiter and access sequencer for the byte-addressable ram block.
- Each requester issues 32-bit word reads or writes.
- The block grants one requester at a time and breaks each word access into four byte accesses on the ram's bytein/byteout/adr/rwn interface.
- It assembles read bytes into a word.
- It sits between CPU-side memory clients (for example, fetch and load/store) and a single ram instance.

Parameters:
logHeight, 3, matches the ram instance: 2^logHeight words, byte address width logHeight+2.

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; forces IDLE and reset values immediately
req0  input  1  port 0 request (level)
we0  input  1  port 0: 1 = write, 0 = read
addr0  input  logHeight  port 0 word address
wdata0  input  32  port 0 write data
ack0  output  1  port 0 completion pulse, one cycle
req1  input  1  port 1 request (level)
we1  input  1  port 1: 1 = write, 0 = read
addr1  input  logHeight  port 1 word address
wdata1  input  32  port 1 write data
ack1  output  1  port 1 completion pulse, one cycle
rdata  output  32  assembled read word, valid while the matching ack is high
busy  output  1  high in every state except IDLE
grant  output  1  index of the port currently being served (held in IDLE)
ram_bytein  output  8  to ram bytein
ram_adr  output  logHeight+2  to ram adr
ram_rwn  output  1  to ram rwn (1 = read, 0 = write)
ram_byteout  input  8  from ram byteout

Behaviour:
- Reset values:
  - ack0 = ack1 = 0, busy = 0, rdata = 0.
  - grant = 0; internal last_grant = 1, so port 0 wins the first tie.
  - ram_adr = 0, ram_rwn = 1, ram_bytein = 0, state = IDLE.
- Byte order is little-endian. Byte k of word a is at ram_adr = {a, k[1:0]} and occupies rdata/wdata bits [8k+7:8k].
- RAM timing:
  - The ram samples adr/rwn/bytein on posedge.
  - Read data appears on ram_byteout after the sampling edge.
  - Written bytes become readable two edges after the write edge.
- States: IDLE, WR0-WR3, RD0-RD3, RDTAIL, DONE.
- IDLE:
  - ram_rwn = 1, ram_adr = 0, ram_bytein = 0.
  - Arbitration: if only one req is high, grant it. If both are high, grant the port != last_grant.
  - On the accepting edge, latch we/addr/wdata of the winner, set grant and last_grant, and go to WR0 or RD0.
  - If no req is high, stay in IDLE.
- WRk (k = 0..3):
  - ram_rwn = 0, ram_adr = {addr, k}, ram_bytein = wdata byte k.
  - WR3 goes to DONE.
- RDk (k = 0..3):
  - ram_rwn = 1, ram_adr = {addr, k}.
  - In RD1..RD3, capture ram_byteout into rdata byte k-1 on the exiting edge.
  - RD3 goes to RDTAIL.
- RDTAIL:
  - ram_rwn = 1, ram_adr = 0.
  - Capture ram_byteout into rdata byte 3.
  - Go to DONE.
- DONE:
  - ack[grant] = 1 for exactly this cycle; the other ack stays 0.
  - Go to IDLE.
- Latency from the accepting edge:
  - Write: ack high in cycle 5. Occupancy is 6 cycles including IDLE.
  - Read: ack high in cycle 6. Occupancy is 7 cycles including IDLE.
- rdata:
  - Holds its value between reads.
  - Unchanged by writes.
  - Bytes update progressively during a read; valid only in the DONE cycle of a read.
- Requester rules:
  - Hold req/we/addr/wdata stable until ack.
  - Deassert req on the edge ending the ack cycle unless issuing a new request.
  - A req high while the block is in IDLE is always a new request.
- Read-after-write: at least 2 edges always separate the WR3 edge and the next RD0 edge (DONE plus IDLE), so no stall logic is needed.
- Back-to-back: a port holding req continuously alternates with the other port under contention. Without contention it is re-granted every 6/7 cycles.
- Address wrap: not applicable. Word address logHeight bits plus k always map in range; addr = 2^logHeight-1 uses bytes 4*(2^logHeight)-4 .. 4*(2^logHeight)-1.
- Reset mid-transaction:
  - Abort immediately with no ack.
  - Bytes already written remain in the ram; the word may be partially written.
  - rdata returns to 0.
- A req change after acceptance is ignored until the next IDLE.

Test Plan:
1. Reset, then port 0 write addr0 = 2, wdata0 = 0xDEADBEEF -> ram_rwn = 0 with ram_adr 8, 9, 10, 11 and ram_bytein EF, BE, AD, DE in cycles 1-4; ack0 in cycle 5; ack1 stays 0.
2. After test 1, port 1 read addr1 = 2 -> ram_adr 8-11 with ram_rwn = 1; ack1 in cycle 6 with rdata = 0xDEADBEEF; busy low the following cycle.
3. req0 and req1 rise on the same cycle after reset (we0 = 1, wdata 0x11223344, addr 0; we1 = 0, addr 0) -> port 0 served first, grant = 0, ack0; then port 1 is granted and rdata = 0x11223344 at ack1.
4. Both reqs held continuously for 4 transactions -> ack order 0, 1, 0, 1; no cycle with both acks high.
5. Write addr = 7 (logHeight = 3), data 0x0A0B0C0D -> ram_adr 28-31; read back returns 0x0A0B0C0D.
6. Assert reset during WR2 of a write 0xCAFEF00D to addr 1 -> busy, ack, and rdata go to 0 asynchronously, no ack is produced; a subsequent read of addr 1 returns bytes 0 and 1 = 0D, F0 with bytes 2-3 unchanged.
